// File: rtl/input_packer.sv
// input_packer: packs a 32-bit valid/ready word stream into 128-bit lines
// and writes them to consecutive SRAM addresses. Frames end on in_last
// (a short final line is zero-padded) or when MAX_WORDS lines have been
// written, in which case the frame is cut off and overflow is flagged.
//
// state  | meaning
// -------+---------------------------------------------------------------
// S_IDLE | after reset; waiting for start, upstream stalled
// S_FILL | accepting beats, writing one line per four beats or per in_last
// S_DONE | frame finished (done, maybe overflow); waiting for a new start

module input_packer #(
    parameter logic [15:0] BASE_ADDR = 16'h0000,
    parameter int          MAX_WORDS = 65536
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         start,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [31:0]  in_data,
    input  logic         in_last,
    output logic         WE,
    output logic [15:0]  WriteAddress,
    output logic [127:0] WriteBus,
    output logic         done,
    output logic         overflow,
    output logic [16:0]  word_count
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Line index at which a line completion without in_last truncates the frame.
    localparam logic [16:0] LAST_LINE = 17'(MAX_WORDS - 1);

    state_t         state_q,    state_d;
    logic           in_ready_q, in_ready_d;
    logic [1:0]     lane_q,     lane_d;
    logic [95:0]    pack_q,     pack_d;
    logic           we_q,       we_d;
    logic [15:0]    addr_q,     addr_d;
    logic [127:0]   bus_q,      bus_d;
    logic           done_q,     done_d;
    logic           overflow_q, overflow_d;
    logic [16:0]    count_q,    count_d;

    logic           beat_accept;
    logic           line_complete;
    logic           at_limit;
    logic [127:0]   line_merged;

    // Only lanes 0..2 need storage: a beat landing in lane 3 always completes
    // the line, so it goes straight from in_data into the merged line.
    // Lanes above the current one are already zero in pack_q, which is what
    // gives the zero padding of a short final line.
    assign beat_accept   = in_ready_q & in_valid;
    assign line_complete = beat_accept & ((lane_q == 2'd3) | in_last);
    assign at_limit      = (count_q == LAST_LINE);
    assign line_merged   = {32'h0, pack_q} | ({96'h0, in_data} << {lane_q, 5'b0});

    // Next-state and next-output decode for the frame sequencer.
    always_comb begin
        state_d    = state_q;
        in_ready_d = in_ready_q;
        lane_d     = lane_q;
        pack_d     = pack_q;
        we_d       = 1'b0;
        addr_d     = addr_q;
        bus_d      = bus_q;
        done_d     = done_q;
        overflow_d = overflow_q;
        count_d    = count_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d    = S_FILL;
                    in_ready_d = 1'b1;
                    lane_d     = 2'd0;
                    pack_d     = '0;
                    done_d     = 1'b0;
                    overflow_d = 1'b0;
                    count_d    = '0;
                end
            end

            S_FILL: begin
                if (line_complete) begin
                    we_d    = 1'b1;
                    addr_d  = BASE_ADDR + count_q[15:0];
                    bus_d   = line_merged;
                    count_d = count_q + 17'd1;
                    lane_d  = 2'd0;
                    pack_d  = '0;
                    if (in_last) begin
                        state_d    = S_DONE;
                        in_ready_d = 1'b0;
                        done_d     = 1'b1;
                    end else if (at_limit) begin
                        // Stop consuming: the rest of the frame stays upstream.
                        state_d    = S_DONE;
                        in_ready_d = 1'b0;
                        done_d     = 1'b1;
                        overflow_d = 1'b1;
                    end
                end else if (beat_accept) begin
                    pack_d = line_merged[95:0];
                    lane_d = lane_q + 2'd1;
                end
            end

            default: begin
                state_d    = S_IDLE;
                in_ready_d = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset drops any partial line unwritten.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            in_ready_q <= 1'b0;
            lane_q     <= 2'd0;
            pack_q     <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            bus_q      <= '0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
            lane_q     <= lane_d;
            pack_q     <= pack_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            bus_q      <= bus_d;
            done_q     <= done_d;
            overflow_q <= overflow_d;
            count_q    <= count_d;
        end
    end

    assign in_ready     = in_ready_q;
    assign WE           = we_q;
    assign WriteAddress = addr_q;
    assign WriteBus     = bus_q;
    assign done         = done_q;
    assign overflow     = overflow_q;
    assign word_count   = count_q;

endmodule

// File: tb/tb_input_packer.sv
// Bench for input_packer. Two instances share the input stream: instance 0
// uses default parameters, instance 1 uses BASE_ADDR=FFFE, MAX_WORDS=4.
module tb_input_packer;

    logic         clock = 1'b0;
    logic         reset, start, in_valid, in_last;
    logic [31:0]  in_data;
    logic         rdy  [2];
    logic         we   [2];
    logic [15:0]  addr [2];
    logic [127:0] bus  [2];
    logic         dn   [2];
    logic         ovf  [2];
    logic [16:0]  cnt  [2];

    int n_vec = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    input_packer u_dut0 (
        .clock(clock), .reset(reset), .start(start), .in_valid(in_valid),
        .in_ready(rdy[0]), .in_data(in_data), .in_last(in_last), .WE(we[0]),
        .WriteAddress(addr[0]), .WriteBus(bus[0]), .done(dn[0]),
        .overflow(ovf[0]), .word_count(cnt[0]));

    input_packer #(.BASE_ADDR(16'hFFFE), .MAX_WORDS(4)) u_dut1 (
        .clock(clock), .reset(reset), .start(start), .in_valid(in_valid),
        .in_ready(rdy[1]), .in_data(in_data), .in_last(in_last), .WE(we[1]),
        .WriteAddress(addr[1]), .WriteBus(bus[1]), .done(dn[1]),
        .overflow(ovf[1]), .word_count(cnt[1]));

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    function automatic int base_of(input int k);
        return (k == 0) ? 0 : 'hFFFE;
    endfunction
    function automatic int limit_of(input int k);
        return (k == 0) ? 65536 : 4;
    endfunction

    logic         m_en = 1'b0;
    logic         m_act [2];
    logic         m_done[2];
    logic         m_ovf [2];
    logic         m_we  [2];
    logic [15:0]  m_addr[2];
    logic [127:0] m_bus [2];
    int           m_cnt [2];
    int           m_n   [2];
    logic [31:0]  m_w   [2][4];

    always @(posedge clock) begin
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                m_act[k] = 0; m_done[k] = 0; m_ovf[k] = 0; m_we[k] = 0;
                m_addr[k] = 0; m_bus[k] = 0; m_cnt[k] = 0; m_n[k] = 0;
            end else begin
                m_we[k] = 0;
                if (!m_act[k]) begin
                    if (start) begin
                        m_act[k] = 1; m_done[k] = 0; m_ovf[k] = 0;
                        m_cnt[k] = 0; m_n[k] = 0;
                    end
                end else if (in_valid) begin
                    m_w[k][m_n[k]] = in_data;
                    m_n[k]++;
                    if (m_n[k] == 4 || in_last) begin
                        m_bus[k] = '0;
                        for (int j = 0; j < m_n[k]; j++)
                            m_bus[k] = m_bus[k] | (128'(m_w[k][j]) << (32 * j));
                        m_addr[k] = 16'((base_of(k) + m_cnt[k]) % 65536);
                        m_we[k] = 1;
                        m_cnt[k]++;
                        m_n[k] = 0;
                        if (in_last) begin
                            m_act[k] = 0; m_done[k] = 1;
                        end else if (m_cnt[k] == limit_of(k)) begin
                            m_act[k] = 0; m_done[k] = 1; m_ovf[k] = 1;
                        end
                    end
                end
            end
        end
        if (reset) m_en = 1'b1;
    end

    // Write log and per-cycle comparison against the model.
    logic [15:0]  la0[$], la1[$];
    logic [127:0] lb0[$], lb1[$];
    int           wcnt[2];

    always @(negedge clock) begin
        if (we[0] === 1'b1) begin la0.push_back(addr[0]); lb0.push_back(bus[0]); wcnt[0]++; end
        if (we[1] === 1'b1) begin la1.push_back(addr[1]); lb1.push_back(bus[1]); wcnt[1]++; end
        if (m_en) begin
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("m%0d_ready", k), 128'(rdy[k]), 128'(m_act[k]));
                chk($sformatf("m%0d_we", k),    128'(we[k]),  128'(m_we[k]));
                chk($sformatf("m%0d_addr", k),  128'(addr[k]), 128'(m_addr[k]));
                chk($sformatf("m%0d_bus", k),   bus[k],        m_bus[k]);
                chk($sformatf("m%0d_done", k),  128'(dn[k]),   128'(m_done[k]));
                chk($sformatf("m%0d_ovf", k),   128'(ovf[k]),  128'(m_ovf[k]));
                chk($sformatf("m%0d_cnt", k),   128'(cnt[k]),  128'(17'(m_cnt[k])));
            end
        end
    end

    // ---------------- directed vector table (instance 0) ----------------
    typedef struct {
        logic         st, v, l;
        logic [31:0]  d;
        logic         e_rdy, e_we;
        logic [15:0]  e_addr;
        logic [127:0] e_bus;
        logic         e_done, e_ovf;
        logic [16:0]  e_cnt;
    } vec_t;
    vec_t vecs[$];

    task automatic add(input logic st, v, l, input logic [31:0] d,
                       input logic rdy_e, we_e, input logic [15:0] a,
                       input logic [127:0] b, input logic dn_e, ov_e,
                       input logic [16:0] c);
        vec_t t;
        t.st = st; t.v = v; t.l = l; t.d = d;
        t.e_rdy = rdy_e; t.e_we = we_e; t.e_addr = a; t.e_bus = b;
        t.e_done = dn_e; t.e_ovf = ov_e; t.e_cnt = c;
        vecs.push_back(t);
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic beat(input logic [31:0] d, input logic l);
        in_valid = 1'b1; in_data = d; in_last = l; start = 1'b0;
        cyc();
    endtask

    task automatic idle();
        in_valid = 1'b0; in_last = 1'b0; start = 1'b0;
        cyc();
    endtask

    task automatic clear_logs();
        la0.delete(); lb0.delete(); la1.delete(); lb1.delete();
        wcnt[0] = 0; wcnt[1] = 0;
    endtask

    localparam logic [127:0] L0 = 128'h00000003_00000002_00000001_00000000;
    localparam logic [127:0] L1 = 128'h00000007_00000006_00000005_00000004;
    localparam logic [127:0] P4 = 128'h00000000_00000000_00000000_00000004;

    initial begin
        logic [127:0] blk;
        int beats, tries;
        logic v, acc;

        reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
        wcnt[0] = 0; wcnt[1] = 0;

        // two full lines, then a partial frame
        add(1,0,0,0, 1,0,16'd0,'0,0,0,0);
        for (int i = 0; i < 3; i++) add(0,1,0,i, 1,0,16'd0,'0,0,0,0);
        add(0,1,0,3, 1,1,16'd0,L0,0,0,1);
        for (int i = 4; i < 7; i++) add(0,1,0,i, 1,0,16'd0,L0,0,0,1);
        add(0,1,1,7, 0,1,16'd1,L1,1,0,2);
        add(0,0,0,0, 0,0,16'd1,L1,1,0,2);
        add(1,0,0,0, 1,0,16'd1,L1,0,0,0);
        for (int i = 0; i < 3; i++) add(0,1,0,i, 1,0,16'd1,L1,0,0,0);
        add(0,1,0,3, 1,1,16'd0,L0,0,0,1);
        add(0,1,1,4, 0,1,16'd1,P4,1,0,2);
        add(0,0,0,0, 0,0,16'd1,P4,1,0,2);

        // reset held two cycles with random inputs
        for (int i = 0; i < 2; i++) begin
            start = 1'($urandom_range(0,1)); in_valid = 1'($urandom_range(0,1));
            in_last = 1'($urandom_range(0,1)); in_data = $urandom;
            cyc();
            for (int k = 0; k < 2; k++) begin
                chk("rst_ready", 128'(rdy[k]), 0);
                chk("rst_we",    128'(we[k]), 0);
                chk("rst_addr",  128'(addr[k]), 0);
                chk("rst_bus",   bus[k], 0);
                chk("rst_done",  128'(dn[k]), 0);
                chk("rst_ovf",   128'(ovf[k]), 0);
                chk("rst_cnt",   128'(cnt[k]), 0);
            end
        end
        chk("rst_we_pulses", 128'(wcnt[0] + wcnt[1]), 0);
        reset = 1'b0;
        idle();
        clear_logs();

        // table-driven vectors
        for (int i = 0; i < vecs.size(); i++) begin
            start = vecs[i].st; in_valid = vecs[i].v; in_last = vecs[i].l; in_data = vecs[i].d;
            cyc();
            chk($sformatf("v%0d_ready", i), 128'(rdy[0]), 128'(vecs[i].e_rdy));
            chk($sformatf("v%0d_we", i),    128'(we[0]),  128'(vecs[i].e_we));
            chk($sformatf("v%0d_addr", i),  128'(addr[0]), 128'(vecs[i].e_addr));
            chk($sformatf("v%0d_bus", i),   bus[0], vecs[i].e_bus);
            chk($sformatf("v%0d_done", i),  128'(dn[0]), 128'(vecs[i].e_done));
            chk($sformatf("v%0d_ovf", i),   128'(ovf[0]), 128'(vecs[i].e_ovf));
            chk($sformatf("v%0d_cnt", i),   128'(cnt[0]), 128'(vecs[i].e_cnt));
        end
        chk("table_we_pulses", 128'(wcnt[0]), 4);

        // bubbles: same data as two full lines, in_valid low about half the time
        start = 1'b1; in_valid = 1'b0; cyc(); start = 1'b0;
        clear_logs();
        beats = 0; tries = 0;
        while (beats < 8 && tries < 200) begin
            v = 1'($urandom_range(0,1));
            in_valid = v; in_data = beats; in_last = (beats == 7);
            acc = v & rdy[0];
            cyc();
            if (acc) beats++;
            tries++;
        end
        idle(); idle();
        chk("bub_beats", 128'(beats), 8);
        chk("bub_we_pulses", 128'(wcnt[0]), 2);
        chk("bub_nlines", 128'(la0.size()), 2);
        if (la0.size() >= 2) begin
            chk("bub_addr0", 128'(la0[0]), 0);
            chk("bub_bus0",  lb0[0], L0);
            chk("bub_addr1", 128'(la0[1]), 1);
            chk("bub_bus1",  lb0[1], L1);
        end
        chk("bub_done", 128'(dn[0]), 1);
        chk("bub_cnt",  128'(cnt[0]), 2);

        // reset mid-frame discards the partial line
        start = 1'b1; cyc(); start = 1'b0;
        clear_logs();
        beat(32'hDEAD0000, 1'b0);
        beat(32'hDEAD0001, 1'b0);
        reset = 1'b1; in_valid = 1'b1; in_data = 32'hDEAD0002; in_last = 1'b0;
        cyc();
        reset = 1'b0;
        for (int k = 0; k < 2; k++) begin
            chk("mid_ready", 128'(rdy[k]), 0);
            chk("mid_cnt",   128'(cnt[k]), 0);
            chk("mid_bus",   bus[k], 0);
        end
        idle();
        chk("mid_we_pulses", 128'(wcnt[0] + wcnt[1]), 0);
        start = 1'b1; cyc(); start = 1'b0;
        for (int i = 0; i < 4; i++) beat(32'hA0 + i, 1'b0);
        idle();
        blk = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
        chk("mid_nlines0", 128'(la0.size()), 1);
        chk("mid_nlines1", 128'(la1.size()), 1);
        if (la0.size() >= 1) begin
            chk("mid_addr0", 128'(la0[0]), 0);
            chk("mid_bus0",  lb0[0], blk);
        end
        if (la1.size() >= 1) begin
            chk("mid_addr1", 128'(la1[0]), 128'h0000_FFFE);
            chk("mid_bus1",  lb1[0], blk);
        end

        // overflow on instance 1: 20 beats, no in_last, limit 4 lines
        reset = 1'b1; idle(); reset = 1'b0;
        start = 1'b1; cyc(); start = 1'b0;
        clear_logs();
        for (int i = 0; i < 20; i++) beat(100 + i, 1'b0);
        idle();
        chk("ovf_nlines", 128'(la1.size()), 4);
        if (la1.size() >= 4) begin
            chk("ovf_addr0", 128'(la1[0]), 128'h0000_FFFE);
            chk("ovf_addr1", 128'(la1[1]), 128'h0000_FFFF);
            chk("ovf_addr2", 128'(la1[2]), 0);
            chk("ovf_addr3", 128'(la1[3]), 1);
            chk("ovf_bus0",  lb1[0], {32'd103, 32'd102, 32'd101, 32'd100});
            chk("ovf_bus3",  lb1[3], {32'd115, 32'd114, 32'd113, 32'd112});
        end
        chk("ovf_ready", 128'(rdy[1]), 0);
        chk("ovf_done",  128'(dn[1]), 1);
        chk("ovf_flag",  128'(ovf[1]), 1);
        chk("ovf_cnt",   128'(cnt[1]), 4);

        // randomized traffic, checked every cycle by the model
        reset = 1'b1; idle(); reset = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            reset    = ($urandom_range(0,255) == 0);
            start    = ($urandom_range(0,15) == 0);
            in_valid = ($urandom_range(0,3) != 0);
            in_last  = ($urandom_range(0,7) == 0);
            in_data  = $urandom;
            cyc();
        end
        reset = 1'b0;
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
